ssd_min_sel: RTL and testbench
==============================

# ssd_min_sel

Best-match selector for the block-matching SSD datapath. Sits directly downstream of the SSD accumulator PE. Consumes its `z`/`z_valid` stream, one completed SSD per search candidate in raster order, and tracks the minimum SSD and its candidate coordinates over a full search window. Reports the winning motion vector and its SSD with a one-cycle `done` pulse.

## Interface
- `SRCH_W`, default 8: candidates per search row (≥2).
- `SRCH_H`, default 8: search rows (≥2).
- `XW`, default `$clog2(SRCH_W)`: width of the x index.
- `YW`, default `$clog2(SRCH_H)`: width of the y index.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle pulse that begins a new search and discards any search in progress.
- `z` in 20: SSD of the current candidate, unsigned.
- `z_valid` in 1: `z` is valid this cycle.
- `busy` out 1: search in progress.
- `done` out 1: one-cycle pulse; `best_*` are updated in the same cycle.
- `best_ssd` out 20: minimum SSD of the last completed search.
- `best_x` out XW: column index of the winner.
- `best_y` out YW: row index of the winner.

## Operation
- Three states:
  - IDLE: after reset or after DONE.
  - SEARCH: accepting candidates.
  - DONE: lasts exactly one cycle, then returns to IDLE.
- IDLE:
  - `start` → SEARCH.
  - Clears `cx`, `cy` and the `first` flag.
  - Sets the running min to 20'hFFFFF.
  - `z_valid` is ignored in IDLE, including when it arrives in the same cycle as `start`.
- SEARCH: each `z_valid` accepts one candidate at (`cx`, `cy`).
  - The first accepted candidate always loads the running min and index, so an all-ones SSD still yields (0,0).
  - Later candidates replace the min only if `z` < min (strict). On ties the earliest candidate in raster order is kept.
  - `cx` wraps to 0 at `SRCH_W`-1 and `cy` increments.
  - Accepting candidate (`SRCH_W`-1, `SRCH_H`-1) → DONE.
  - Accepted candidates need not be contiguous; gaps in `z_valid` are allowed.
- `start` while in SEARCH restarts the search.
  - A `z_valid` arriving in the same cycle is discarded.
  - The running state is reinitialised.
  - `best_*` keep their previous values.
- `start` while in DONE is honoured: the next state is SEARCH and `done` still pulses.
- DONE:
  - `best_ssd`, `best_x` and `best_y` are loaded from the running min/index, taking the final candidate into account.
  - `done`=1 for this one cycle.
  - `z_valid` in DONE is ignored.
- `best_*` hold their values until the next DONE.
- Reset mid-search: all state and outputs return to reset values immediately. No `done` is produced.

## Timing
- Reset values:
  - `busy`=0, `done`=0.
  - `best_ssd`=20'hFFFFF.
  - `best_x`=0, `best_y`=0.
  - State IDLE.
- `start` at cycle t → `busy`=1 from t+1. The first candidate can be accepted at t+1.
- Last candidate accepted at cycle k:
  - `done`=1 and `best_*` valid at k+1.
  - `busy`=0 at k+1.
- Minimum turnaround: `start` can be given at k+1, and `busy` returns to 1 at k+2.
- All outputs are registered. There is no combinational path from any input to any output.
- Minimum search length: `SRCH_W`·`SRCH_H` cycles of `z_valid` plus one cycle.

## Configuration
- `SSD_ZERO_EXIT_EN` defined: early exit on a perfect match.
  - An accepted candidate with `z`==0 moves the state to DONE immediately, in the same way as a last candidate.
  - `best_ssd`=0 and that candidate's coordinates are reported at the next cycle.
  - Remaining `z_valid` pulses are ignored until the next `start`.
  - A zero on the final candidate behaves identically to a normal finish.
- `SSD_ZERO_EXIT_EN` not defined: a zero SSD is treated like any other value, and the search always runs to completion.

## Test plan
- Reset, SRCH_W=4, SRCH_H=2:
  - Check `best_ssd`=20'hFFFFF, `busy`=0, `done`=0.
  - `start`, then 8 contiguous `z_valid` with z=50,40,60,30,70,30,90,80.
  - Required: `done` one cycle after the 8th sample, `best_ssd`=30, (x,y)=(3,0), tie kept earliest.
- Same stream with 3-cycle gaps between samples → identical result. `busy` stays high throughout the gaps.
- All 8 samples z=20'hFFFFF → `best_ssd`=20'hFFFFF, (0,0).
- `start`, 5 samples, `start` again with `z_valid`=1 and z=1 in the same cycle, then 8 samples all z=100.
  - Required: the z=1 sample is discarded, `best_ssd`=100, (0,0), exactly one `done`.
- `start`, 3 samples, then `rst_n` low → `busy`=0 and `best_*` at reset values with no `done`. A fresh search afterwards completes normally.
- With `SSD_ZERO_EXIT_EN`: z=9,0,5,… → `done` the cycle after z=0, `best_ssd`=0, (1,0). Later `z_valid` pulses are ignored. Without the macro: `best_ssd`=0 only after all 8 samples.

Source files
------------

// File: rtl/ssd_min_sel.sv
// Tracks the minimum SSD and its raster coordinates over one search window, pulsing done with the winner.
// Optional early exit on a zero SSD is enabled by defining SSD_ZERO_EXIT_EN.
module ssd_min_sel #(
   parameter int SRCH_W = 8,
   parameter int SRCH_H = 8,
   parameter int XW     = $clog2(SRCH_W),
   parameter int YW     = $clog2(SRCH_H)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic [19:0]   z,
   input  logic          z_valid,
   output logic          busy,
   output logic          done,
   output logic [19:0]   best_ssd,
   output logic [XW-1:0] best_x,
   output logic [YW-1:0] best_y
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SEARCH = 2'd1,
      S_DONE   = 2'd2
   } state_t;

   localparam logic [XW-1:0] X_LAST = XW'(SRCH_W - 1);
   localparam logic [YW-1:0] Y_LAST = YW'(SRCH_H - 1);

   state_t        state, state_nxt;
   logic [XW-1:0] cx, min_x, cand_x;
   logic [YW-1:0] cy, min_y, cand_y;
   logic [19:0]   min_ssd, cand_ssd;
   logic          seen;
   logic          accept, take, last, zero_hit, finish, init_run;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   if (start) state_nxt = S_SEARCH;
         S_SEARCH: begin
            if (start)       state_nxt = S_SEARCH;
            else if (finish) state_nxt = S_DONE;
         end
         S_DONE:   state_nxt = start ? S_SEARCH : S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   // Datapath control; a start in the same cycle as z_valid discards the sample
   always_comb begin
      accept   = (state == S_SEARCH) && z_valid && !start;
      take     = accept && (!seen || (z < min_ssd));
      last     = (cx == X_LAST) && (cy == Y_LAST);
`ifdef SSD_ZERO_EXIT_EN
      zero_hit = (z == 20'd0);
`else
      zero_hit = 1'b0;
`endif
      finish   = accept && (last || zero_hit);
      init_run = start || (state != S_SEARCH);
      cand_ssd = take ? z  : min_ssd;
      cand_x   = take ? cx : min_x;
      cand_y   = take ? cy : min_y;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cx      <= '0;
         cy      <= '0;
         seen    <= 1'b0;
         min_ssd <= 20'hFFFFF;
         min_x   <= '0;
         min_y   <= '0;
      end else if (init_run) begin
         cx      <= '0;
         cy      <= '0;
         seen    <= 1'b0;
         min_ssd <= 20'hFFFFF;
         min_x   <= '0;
         min_y   <= '0;
      end else if (accept) begin
         seen    <= 1'b1;
         min_ssd <= cand_ssd;
         min_x   <= cand_x;
         min_y   <= cand_y;
         if (cx == X_LAST) begin
            cx <= '0;
            cy <= cy + 1'b1;
         end else begin
            cx <= cx + 1'b1;
         end
      end
   end

   // The winner includes the finishing candidate, so outputs align with done
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy     <= 1'b0;
         done     <= 1'b0;
         best_ssd <= 20'hFFFFF;
         best_x   <= '0;
         best_y   <= '0;
      end else begin
         busy <= (state_nxt == S_SEARCH);
         done <= (state_nxt == S_DONE);
         if (finish && !start) begin
            best_ssd <= cand_ssd;
            best_x   <= cand_x;
            best_y   <= cand_y;
         end
      end
   end

endmodule

// File: tb/tb_ssd_min_sel.sv
// Bench for ssd_min_sel (4x2 window): directed and random searches against a queue-based minimum model.
module tb_ssd_min_sel;
   localparam int W = 4;
   localparam int H = 2;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [19:0] z;
   logic        z_valid;
   logic        busy, done;
   logic [19:0] best_ssd;
   logic [1:0]  best_x;
   logic        best_y;

   int checks = 0;
   int errors = 0;

   logic [19:0] samp[$];
   logic [19:0] exp_ssd;
   int          exp_x, exp_y;

   ssd_min_sel #(.SRCH_W(W), .SRCH_H(H)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .z(z), .z_valid(z_valid),
      .busy(busy), .done(done), .best_ssd(best_ssd), .best_x(best_x), .best_y(best_y)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic chk_best(input string tag);
      chk({tag, "_ssd"}, 32'(best_ssd), 32'(exp_ssd));
      chk({tag, "_x"},   32'(best_x),   32'(exp_x));
      chk({tag, "_y"},   32'(best_y),   32'(exp_y));
   endtask

   // Reference: the sample that ends the search, then the first occurrence of the minimum up to it
   task automatic model(output int end_i, output logic [19:0] ms, output int mi);
      end_i = samp.size() - 1;
`ifdef SSD_ZERO_EXIT_EN
      for (int i = samp.size() - 1; i >= 0; i--)
         if (samp[i] == 20'd0) end_i = i;
`endif
      ms = samp[0];
      mi = 0;
      for (int i = 1; i <= end_i; i++)
         if (samp[i] < ms) begin
            ms = samp[i];
            mi = i;
         end
   endtask

   task automatic do_start(input logic zv, input logic [19:0] zz);
      start = 1'b1; z_valid = zv; z = zz;
      step();
      start = 1'b0; z_valid = 1'b0;
      chk("start_busy", 32'(busy), 32'd1);
      chk("start_done", 32'(done), 32'd0);
   endtask

   // Feeds samp with gap idle cycles after each sample; complete=1 expects the search to finish
   task automatic feed(input int gap, input bit complete);
      int end_i, mi;
      logic [19:0] ms;
      end_i = samp.size();
      ms = '0; mi = 0;
      if (complete) model(end_i, ms, mi);
      for (int i = 0; i < samp.size(); i++) begin
         z_valid = 1'b1; z = samp[i];
         step();
         z_valid = 1'b0;
         if (complete && i == end_i) begin
            exp_ssd = ms; exp_x = mi % W; exp_y = mi / W;
            chk("fin_done", 32'(done), 32'd1);
            chk("fin_busy", 32'(busy), 32'd0);
            chk_best("fin");
         end else begin
            chk("mid_done", 32'(done), 32'd0);
            chk("mid_busy", 32'(busy), (i < end_i) ? 32'd1 : 32'd0);
         end
         for (int g = 0; g < gap; g++) begin
            step();
            chk("gap_busy", 32'(busy), (i < end_i) ? 32'd1 : 32'd0);
            chk("gap_done", 32'(done), 32'd0);
         end
      end
   endtask

   task automatic post_check();
      step();
      chk("post_done", 32'(done), 32'd0);
      chk("post_busy", 32'(busy), 32'd0);
      chk_best("post");
   endtask

   task automatic load(input logic [19:0] a0, a1, a2, a3, a4, a5, a6, a7);
      samp = {a0, a1, a2, a3, a4, a5, a6, a7};
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; z = '0; z_valid = 1'b0;
      exp_ssd = 20'hFFFFF; exp_x = 0; exp_y = 0;
      repeat (3) step();
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk_best("rst");
      rst_n = 1'b1;
      step();

      // Contiguous stream, tie at 30 keeps the earlier (3,0)
      load(50, 40, 60, 30, 70, 30, 90, 80);
      do_start(1'b0, 0);
      feed(0, 1'b1);
      post_check();

      // Same stream with gaps
      do_start(1'b0, 0);
      feed(3, 1'b1);
      post_check();

      // All-ones SSD still reports (0,0)
      load(20'hFFFFF, 20'hFFFFF, 20'hFFFFF, 20'hFFFFF, 20'hFFFFF, 20'hFFFFF, 20'hFFFFF, 20'hFFFFF);
      do_start(1'b0, 0);
      feed(0, 1'b1);
      post_check();

      // Restart mid-search; the sample coinciding with start is dropped
      load(7, 6, 5, 4, 3, 1, 1, 1);
      samp = samp[0:4];
      do_start(1'b0, 0);
      feed(0, 1'b0);
      chk_best("abort_hold");
      do_start(1'b1, 20'd1);
      load(100, 100, 100, 100, 100, 100, 100, 100);
      feed(0, 1'b1);
      post_check();

      // Reset mid-search
      load(11, 12, 13, 0, 0, 0, 0, 0);
      samp = samp[0:2];
      do_start(1'b0, 0);
      feed(0, 1'b0);
      rst_n = 1'b0;
      #1;
      exp_ssd = 20'hFFFFF; exp_x = 0; exp_y = 0;
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_done", 32'(done), 32'd0);
      chk_best("arst");
      step();
      rst_n = 1'b1;
      step();
      chk("arst_nodone", 32'(done), 32'd0);
      load(8, 7, 9, 6, 10, 5, 11, 12);
      do_start(1'b0, 0);
      feed(1, 1'b1);
      post_check();

      // Zero SSD: early exit with the macro, full run without
      load(9, 0, 5, 3, 0, 2, 1, 4);
      do_start(1'b0, 0);
      feed(0, 1'b1);
      post_check();

      // Back-to-back: start in the done cycle
      load(3, 2, 1, 5, 6, 7, 8, 9);
      do_start(1'b0, 0);
      feed(0, 1'b1);
      load(40, 41, 42, 43, 44, 45, 46, 39);
      do_start(1'b0, 0);
      feed(0, 1'b1);
      post_check();

      // Random searches, small value range to provoke ties
      for (int r = 0; r < 6; r++) begin
         samp = {};
         for (int i = 0; i < W * H; i++)
            samp.push_back(($urandom_range(0, 3) == 0) ? 20'($urandom_range(0, 20'hFFFFF))
                                                       : 20'($urandom_range(0, 12)));
         do_start(1'b0, 0);
         feed($urandom_range(0, 2), 1'b1);
         post_check();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
